serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle digit-serial subtractor: diff = a - b, D bits per clock, LSB digit first.
//  Inverse arithmetic companion to the combinational nbit adder; used in the RISC datapath
//  where SUB/compare tolerate latency and area matters more than speed.
//  Valid/ready handshake on both operand and result sides; also produces borrow, zero and signed overflow.
// PARAMETERS
//  N   32  operand/result width; N % D == 0 required (elaboration error otherwise)
//  D    8  digit width processed per cycle; latency scales as N/D
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  operands a/b presented
//  in_ready   out  1  block can accept operands (high only in IDLE)
//  a          in   N  minuend (sampled on in_valid & in_ready)
//  b          in   N  subtrahend (sampled on in_valid & in_ready)
//  out_valid  out  1  result registers valid (high only in DONE)
//  out_ready  in   1  consumer accepts result
//  diff       out  N  a - b modulo 2^N
//  borrow     out  1  1 iff unsigned a < b
//  zero       out  1  1 iff diff == 0
//  ovf        out  1  signed overflow: a[N-1]!=b[N-1] && diff[N-1]!=a[N-1]
//  busy       out  1  high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, digit counter=0, internal borrow=0; diff=0, borrow=0,
//    zero=0, ovf=0, out_valid=0, busy=0, in_ready=1 from reset release.
//  - FSM: IDLE -(in_valid&in_ready)-> RUN; RUN -(last digit)-> DONE; DONE -(out_ready)-> IDLE.
//  - Accept edge: latch a, b into shift regs; clear counter; borrow-in = 0; diff/flags cleared.
//  - RUN, each edge: digit k = bits [D*k+D-1 : D*k]; ripple D full_subtractor cells with borrow
//    chain (cell: d=x^y^bi, bo=(~x&y)|(~(x^y)&bi)); write digit into diff, register borrow-out; k++.
//  - After the N/D-th RUN edge: borrow, zero, ovf registered from final values; state=DONE.
//  - Latency: out_valid rises exactly N/D cycles after the accept edge (4 for defaults).
//  - out_valid and all result outputs hold stable while out_valid & !out_ready (backpressure, unbounded).
//  - DONE & out_ready: result consumed; next edge -> IDLE, out_valid=0. No same-cycle new accept
//    (in_ready=0 in DONE); minimum issue interval N/D+2 cycles.
//  - in_valid in RUN/DONE ignored; a/b changes after accept do not affect result.
//  - Counter wraps to 0 on leaving RUN; counter width = clog2(N/D), min 1 bit (N==D legal: 1 RUN cycle).
//  - rst_n asserted mid-RUN or in DONE: immediate abort to reset values; in-flight result discarded.
//  - Outputs driven only from registers; no combinational path from in_valid/out_ready to outputs
//    except in_ready/out_valid, which are decoded from state alone.
// STRUCTURE
//  - Shared package: FSM state enum {IDLE, RUN, DONE} (2-bit) and default N/D constants.
//  - One sub-module: full_subtractor (1-bit, combinational), instantiated D times via generate.
//  - Top holds FSM, counter, operand shift regs, diff register, borrow/flag registers.
// TESTING
//  1 a=5, b=3 -> after 4 cycles out_valid=1, diff=0x00000002, borrow=0, zero=0, ovf=0.
//  2 a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, ovf=0; a=b=0x1234ABCD -> diff=0, zero=1, borrow=0.
//  3 a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, borrow=0; a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow=1.
//  4 out_ready held 0 for 10 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; then accepted.
//  5 rst_n low 2 cycles mid-RUN (after 2 digits) -> all outputs at reset values, in_ready=1 next cycle.
//  6 Back-to-back random 1000 ops, N=32 with D=1,8,32 -> match a-b reference model, latency N/D each.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding,
// default geometry and the digit-counter width helper.
package serial_subtractor_pkg;

  localparam int unsigned DEF_N = 32'd32;
  localparam int unsigned DEF_D = 32'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold 0..digits-1; a single-digit operand still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits > 32'd1) ? $clog2(digits) : 32'd1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = x_i ^ y_i ^ bi_i;
  assign bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b, D bits per clock, LSB digit first.
// Operands are shifted right one digit per RUN cycle; result digits enter
// the diff register from the top so the last digit lands in the MSBs.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned D = DEF_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         zero,
  output logic         ovf,
  output logic         busy
);

  localparam int unsigned DIGITS = N / D;
  localparam int unsigned CW     = cnt_width(DIGITS);
  localparam int unsigned TOP    = N - D;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 32'd1);

  if ((N % D) != 32'd0) begin : g_bad_geometry
    $error("serial_subtractor: N must be a multiple of D");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bint_q, bint_d;
  logic            borrow_q, borrow_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  logic [D:0]      chain_s;
  logic [D-1:0]    dig_s;
  logic [N-1:0]    dig_ext_s;
  logic [N-1:0]    diff_shift_s;

  // Current digit sits in the low D bits of the operand shift registers.
  assign chain_s[0] = bint_q;

  for (genvar i = 0; i < D; i++) begin : g_cell
    full_subtractor u_fs (
      .x_i  (a_q[i]),
      .y_i  (b_q[i]),
      .bi_i (chain_s[i]),
      .d_o  (dig_s[i]),
      .bo_o (chain_s[i+1])
    );
  end

  // New digit enters at the top; previous digits move down one digit slot.
  assign dig_ext_s    = N'(dig_s) << TOP;
  assign diff_shift_s = (diff_q >> D) | dig_ext_s;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bint_d   = bint_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          cnt_d    = '0;
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          bint_d   = 1'b0;
          borrow_d = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d    = a_q >> D;
        b_d    = b_q >> D;
        diff_d = diff_shift_s;
        bint_d = chain_s[D];
        if (cnt_q == LAST) begin
          // Top digit: a_q/b_q low bits now hold the operand sign bits.
          state_d  = DONE;
          cnt_d    = '0;
          borrow_d = chain_s[D];
          zero_d   = (diff_shift_s == '0);
          ovf_d    = (a_q[D-1] != b_q[D-1]) && (dig_s[D-1] != a_q[D-1]);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and result registers with async abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bint_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bint_q   <= bint_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
